prog_load_ctrl: RTL and testbench
=================================

Name: prog_load_ctrl

Overview:
- Sequences the 256x16 program memory between two owners: a host loader stream and the CPU instruction-fetch port.
- A start pulse causes it to zero the whole memory, then accept up to DEPTH words over a valid/ready stream, then release the CPU.
- After that the fetch port reads the memory until the next start.
- It replaces file-based preload with a controlled, restartable load sequence.

Parameters:
- ADDR_W, 8, memory address width.
- DATA_W, 16, instruction word width.
- DEPTH, 256, number of memory words; must equal 2**ADDR_W.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse: begin a CLEAR+LOAD sequence.
- ld_valid  in  1  loader word available.
- ld_data  in  DATA_W  loader word.
- ld_last  in  1  qualifies ld_data as the final word of the program.
- ld_ready  out  1  controller accepts a loader word this cycle.
- fetch_req  in  1  CPU fetch request.
- fetch_addr  in  ADDR_W  CPU fetch address.
- fetch_valid  out  1  fetch_data valid (one cycle after an accepted fetch_req).
- fetch_data  out  DATA_W  fetched instruction.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data; synchronous memory, 1-cycle read latency.
- cpu_hold  out  1  high while the CPU must stall.
- done  out  1  high in RUN.
- word_count  out  ADDR_W+1  words written by the last LOAD (0..DEPTH).
- trunc  out  1  sticky: the DEPTH-th word was accepted without ld_last.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset state: state=IDLE, cnt=0, word_count=0, trunc=0, fetch_valid=0, done=0, cpu_hold=1, ld_ready=0, mem_we=0.
  - mem_we, mem_addr and mem_wdata are decoded from registered state, so mem_we falls on rst assertion without waiting for a clock.
- FSM states: IDLE, CLEAR, LOAD, RUN.
- IDLE:
  - cpu_hold=1; fetch_req ignored.
  - start -> CLEAR, with cnt=0 and trunc=0.
- CLEAR:
  - Each cycle: mem_we=1, mem_addr=cnt, mem_wdata=0, cnt++.
  - After the write at cnt=DEPTH-1 (exactly DEPTH cycles): -> LOAD with cnt=0.
  - start and ld_valid are ignored; ld_ready=0.
- LOAD:
  - ld_ready=1.
  - A transfer occurs when ld_valid&&ld_ready. On a transfer: mem_we=1, mem_addr=cnt[ADDR_W-1:0], mem_wdata=ld_data, cnt++.
  - No transfer: mem_we=0.
  - Transfer with ld_last: -> RUN, word_count=cnt+1.
  - Transfer at cnt=DEPTH-1 without ld_last: -> RUN, word_count=DEPTH, trunc=1.
  - A ld_valid beat presented after the transition is not accepted (ld_ready=0 in RUN).
  - start ignored.
- RUN:
  - done=1, cpu_hold=0, mem_we=0.
  - mem_addr=fetch_addr (combinational pass-through).
  - fetch_valid is registered fetch_req; fetch_data=mem_rdata. Back-to-back fetches give one result per cycle.
  - start -> CLEAR next cycle; cpu_hold=1 and done=0 from that cycle.
  - A fetch accepted in the same cycle as start still produces its fetch_valid.
- fetch_req outside RUN never produces fetch_valid.
- start in the same cycle as rst: rst wins.
- Reset mid-CLEAR or mid-LOAD:
  - Immediate return to IDLE.
  - Memory contents are undefined until the next full sequence.
  - word_count and trunc are cleared.
- Arithmetic: cnt is ADDR_W+1 bits wide, so the value DEPTH is representable with no wrap. mem_addr uses the low ADDR_W bits.

Decomposition:
- Shared package prog_pkg holds:
  - the state enum (IDLE, CLEAR, LOAD, RUN);
  - ADDR_W, DATA_W, DEPTH constants;
  - the word type.
- No sub-module. The memory itself is external; a behavioural prog_mem (1R/1W, synchronous read) lives in the bench.

Test Plan:
- Reset, then fetch_req=1 with fetch_addr=0x05 -> fetch_valid stays 0, cpu_hold=1, done=0, all outputs at reset values.
- start; stream 3 words 0x1234, 0xBEEF, 0x0F0F (last on the third) with ld_valid held high -> 256 CLEAR writes of 0, then writes at 0..2. done rises the cycle after the third transfer, word_count=3, trunc=0. Fetch at addr 1 returns 0xBEEF one cycle later; fetch at addr 200 returns 0x0000.
- Loader with random ld_valid gaps, 5 words -> writes occur only on valid&&ready cycles at consecutive addresses 0..4; word_count=5.
- Stream 300 words with no ld_last -> exactly 256 writes (addr 255 = word 256), trunc=1, word_count=256. Beats 257..300 see ld_ready=0.
- In RUN, assert rst during a fetch, then start; then assert rst again at LOAD cnt=10 -> state IDLE immediately, mem_we=0 without a clock edge, word_count=0, cpu_hold=1.
- In RUN, pulse start while fetch_req=1 -> that fetch's fetch_valid still appears; the next cycle is CLEAR with cpu_hold=1 and done=0; further fetch_req are ignored.

Source files
------------

// File: rtl/prog_pkg.sv
// Shared types and sizing for the program-memory load controller.
package prog_pkg;

   localparam int unsigned ADDR_W = 8;
   localparam int unsigned DATA_W = 16;
   localparam int unsigned DEPTH  = 256;
   localparam int unsigned CNT_W  = ADDR_W + 1;

   typedef logic [DATA_W-1:0] word_t;
   typedef logic [ADDR_W-1:0] addr_t;
   typedef logic [CNT_W-1:0]  cnt_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CLEAR = 2'd1,
      LOAD  = 2'd2,
      RUN   = 2'd3
   } state_t;

endpackage

// File: rtl/prog_load_ctrl.sv
// Arbitrates the program memory between a host loader stream and CPU fetch:
// start -> zero every word -> stream in the program -> hand memory to the CPU.
module prog_load_ctrl
   import prog_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              ld_valid,
   input  logic [DATA_W-1:0] ld_data,
   input  logic              ld_last,
   output logic              ld_ready,
   input  logic              fetch_req,
   input  logic [ADDR_W-1:0] fetch_addr,
   output logic              fetch_valid,
   output logic [DATA_W-1:0] fetch_data,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              cpu_hold,
   output logic              done,
   output logic [ADDR_W:0]   word_count,
   output logic              trunc
);

   localparam cnt_t LAST_CNT  = cnt_t'(DEPTH - 1);
   localparam cnt_t DEPTH_CNT = cnt_t'(DEPTH);

   state_t state, state_nxt;
   cnt_t   cnt, cnt_nxt;
   cnt_t   word_count_nxt;
   logic   trunc_nxt;
   logic   xfer;

   assign xfer = (state == LOAD) && ld_valid;

   // State and datapath registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         cnt         <= '0;
         word_count  <= '0;
         trunc       <= 1'b0;
         fetch_valid <= 1'b0;
      end else begin
         state       <= state_nxt;
         cnt         <= cnt_nxt;
         word_count  <= word_count_nxt;
         trunc       <= trunc_nxt;
         fetch_valid <= (state == RUN) && fetch_req;
      end
   end

   // Next-state and counter update
   always_comb begin
      state_nxt      = state;
      cnt_nxt        = cnt;
      word_count_nxt = word_count;
      trunc_nxt      = trunc;
      case (state)
         IDLE: begin
            if (start) begin
               state_nxt = CLEAR;
               cnt_nxt   = '0;
               trunc_nxt = 1'b0;
            end
         end
         CLEAR: begin
            if (cnt == LAST_CNT) begin
               state_nxt = LOAD;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt + cnt_t'(1);
            end
         end
         LOAD: begin
            if (xfer) begin
               cnt_nxt = cnt + cnt_t'(1);
               if (ld_last) begin
                  state_nxt      = RUN;
                  word_count_nxt = cnt + cnt_t'(1);
               end else if (cnt == LAST_CNT) begin
                  // memory full before the loader signalled its last word
                  state_nxt      = RUN;
                  word_count_nxt = DEPTH_CNT;
                  trunc_nxt      = 1'b1;
               end
            end
         end
         RUN: begin
            if (start) begin
               state_nxt = CLEAR;
               cnt_nxt   = '0;
               trunc_nxt = 1'b0;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Output decode from registered state; memory port follows the owner
   always_comb begin
      mem_we    = 1'b0;
      mem_addr  = cnt[ADDR_W-1:0];
      mem_wdata = '0;
      ld_ready  = 1'b0;
      cpu_hold  = 1'b1;
      done      = 1'b0;
      case (state)
         CLEAR: mem_we = 1'b1;
         LOAD: begin
            ld_ready  = 1'b1;
            mem_we    = xfer;
            mem_wdata = ld_data;
         end
         RUN: begin
            cpu_hold = 1'b0;
            done     = 1'b1;
            mem_addr = fetch_addr;
         end
         default: ;
      endcase
   end

   assign fetch_data = mem_rdata;

endmodule

// File: tb/tb_prog_load_ctrl.sv
// Self-checking bench for prog_load_ctrl with a behavioural 1R/1W synchronous memory.
module tb_prog_load_ctrl;
   import prog_pkg::*;

   logic              clk = 1'b0;
   logic              rst;
   logic              start;
   logic              ld_valid;
   logic [DATA_W-1:0] ld_data;
   logic              ld_last;
   logic              ld_ready;
   logic              fetch_req;
   logic [ADDR_W-1:0] fetch_addr;
   logic              fetch_valid;
   logic [DATA_W-1:0] fetch_data;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic              cpu_hold;
   logic              done;
   logic [ADDR_W:0]   word_count;
   logic              trunc;

   int n_chk  = 0;
   int n_fail = 0;

   word_t mem [DEPTH];
   addr_t wr_addr [$];
   word_t wr_data [$];
   word_t words [300];

   typedef struct {
      addr_t addr;
      word_t exp;
   } fvec_t;
   fvec_t fv [7];

   always #5 clk = ~clk;

   prog_load_ctrl dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .ld_valid   (ld_valid),
      .ld_data    (ld_data),
      .ld_last    (ld_last),
      .ld_ready   (ld_ready),
      .fetch_req  (fetch_req),
      .fetch_addr (fetch_addr),
      .fetch_valid(fetch_valid),
      .fetch_data (fetch_data),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata),
      .cpu_hold   (cpu_hold),
      .done       (done),
      .word_count (word_count),
      .trunc      (trunc)
   );

   // behavioural program memory
   always @(posedge clk) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      mem_rdata <= mem[mem_addr];
   end

   // write log
   always @(posedge clk) begin
      if (!rst && mem_we) begin
         wr_addr.push_back(mem_addr);
         wr_data.push_back(mem_wdata);
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic run_load(input int n, input bit use_last, input bit gaps, output int acc);
      bit x;
      wr_addr.delete();
      wr_data.delete();
      start = 1'b1;
      tick();
      start = 1'b0;
      acc = 0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         ld_valid = (acc < n) && (gaps ? ($urandom_range(0, 1) == 1) : 1'b1);
         ld_data  = (acc < n) ? words[acc] : '0;
         ld_last  = use_last && (acc == n - 1);
         #1;
         x = ld_valid && ld_ready;
         tick();
         if (x) acc++;
         if (x && use_last && acc == n) chk("done_after_last", done, 1);
         if (done) break;
      end
      ld_valid = 1'b0;
      ld_last  = 1'b0;
      chk("load_reaches_run", done, 1);
   endtask

   task automatic check_writes(input int n, input string nm);
      int errs;
      chk({nm, "_write_count"}, wr_addr.size(), DEPTH + n);
      if (wr_addr.size() >= DEPTH + n) begin
         errs = 0;
         for (int i = 0; i < DEPTH; i++)
            if (wr_addr[i] !== addr_t'(i) || wr_data[i] !== '0) errs++;
         chk({nm, "_clear_writes_bad"}, errs, 0);
         errs = 0;
         for (int i = 0; i < n; i++)
            if (wr_addr[DEPTH+i] !== addr_t'(i) || wr_data[DEPTH+i] !== words[i]) errs++;
         chk({nm, "_load_writes_bad"}, errs, 0);
      end
   endtask

   task automatic do_fetch(input addr_t a, input word_t exp, input string nm);
      fetch_req  = 1'b1;
      fetch_addr = a;
      tick();
      chk({nm, "_valid"}, fetch_valid, 1);
      chk({nm, "_data"}, fetch_data, exp);
      fetch_req = 1'b0;
   endtask

   initial begin
      int acc;
      int rdy;
      int w;
      int nwr;
      rst = 1'b1; start = 1'b0; ld_valid = 1'b0; ld_data = '0; ld_last = 1'b0;
      fetch_req = 1'b0; fetch_addr = '0;
      for (int i = 0; i < 300; i++) words[i] = word_t'((i * 16'h0107) ^ 16'h3C5A);
      repeat (2) tick();

      // reset values
      chk("rst_cpu_hold", cpu_hold, 1);
      chk("rst_done", done, 0);
      chk("rst_ld_ready", ld_ready, 0);
      chk("rst_mem_we", mem_we, 0);
      chk("rst_word_count", word_count, 0);
      chk("rst_trunc", trunc, 0);
      chk("rst_fetch_valid", fetch_valid, 0);

      // fetch ignored in IDLE
      rst = 1'b0;
      fetch_req = 1'b1;
      fetch_addr = 8'h05;
      repeat (3) tick();
      chk("idle_fetch_valid", fetch_valid, 0);
      chk("idle_cpu_hold", cpu_hold, 1);
      chk("idle_done", done, 0);
      chk("idle_mem_we", mem_we, 0);
      fetch_req = 1'b0;

      // three-word program, ld_valid held high
      words[0] = 16'h1234; words[1] = 16'hBEEF; words[2] = 16'h0F0F;
      run_load(3, 1'b1, 1'b0, acc);
      chk("p3_accepted", acc, 3);
      chk("p3_word_count", word_count, 3);
      chk("p3_trunc", trunc, 0);
      chk("p3_cpu_hold", cpu_hold, 0);
      check_writes(3, "p3");

      fv[0] = '{8'd1,   16'hBEEF};
      fv[1] = '{8'd200, 16'h0000};
      fv[2] = '{8'd0,   16'h1234};
      fv[3] = '{8'd2,   16'h0F0F};
      fv[4] = '{8'd3,   16'h0000};
      fv[5] = '{8'd255, 16'h0000};
      fv[6] = '{8'd128, 16'h0000};
      for (int i = 0; i < 7; i++) begin
         do_fetch(fv[i].addr, fv[i].exp, $sformatf("fetch_vec%0d", i));
         tick();
         chk($sformatf("fetch_vec%0d_single", i), fetch_valid, 0);
      end

      // back-to-back fetches
      fetch_req = 1'b1; fetch_addr = 8'd0;
      tick();
      fetch_addr = 8'd1;
      chk("b2b0_valid", fetch_valid, 1);
      chk("b2b0_data", fetch_data, 16'h1234);
      tick();
      fetch_req = 1'b0;
      chk("b2b1_valid", fetch_valid, 1);
      chk("b2b1_data", fetch_data, 16'hBEEF);

      // five words with random valid gaps
      run_load(5, 1'b1, 1'b1, acc);
      chk("gap_accepted", acc, 5);
      chk("gap_word_count", word_count, 5);
      chk("gap_trunc", trunc, 0);
      check_writes(5, "gap");

      // 300 words without ld_last: truncated at DEPTH
      run_load(300, 1'b0, 1'b0, acc);
      chk("tr_accepted", acc, DEPTH);
      chk("tr_word_count", word_count, DEPTH);
      chk("tr_trunc", trunc, 1);
      check_writes(DEPTH, "tr");
      rdy = 0;
      nwr = wr_addr.size();
      for (int i = DEPTH; i < 300; i++) begin
         ld_valid = 1'b1;
         ld_data  = words[i];
         #1;
         if (ld_ready) rdy++;
         tick();
      end
      ld_valid = 1'b0;
      chk("tr_extra_ready", rdy, 0);
      chk("tr_extra_writes", wr_addr.size(), nwr);
      do_fetch(8'd255, words[255], "tr_fetch255");

      // reset during a fetch in RUN
      fetch_req = 1'b1; fetch_addr = 8'd3;
      #1 rst = 1'b1;
      #1;
      chk("rr_fetch_valid", fetch_valid, 0);
      chk("rr_cpu_hold", cpu_hold, 1);
      chk("rr_done", done, 0);
      chk("rr_word_count", word_count, 0);
      chk("rr_trunc", trunc, 0);
      tick();
      fetch_req = 1'b0;
      rst = 1'b0;
      tick();

      // start together with rst: rst wins
      rst = 1'b1; start = 1'b1;
      tick();
      rst = 1'b0; start = 1'b0;
      tick();
      chk("rst_start_mem_we", mem_we, 0);
      chk("rst_start_hold", cpu_hold, 1);

      // reset mid-LOAD at cnt=10
      start = 1'b1;
      tick();
      start = 1'b0;
      w = 0;
      while (!ld_ready && w < 400) begin
         tick();
         w++;
      end
      chk("ml_reach_load", ld_ready, 1);
      ld_valid = 1'b1; ld_last = 1'b0;
      for (int i = 0; i < 10; i++) begin
         ld_data = words[i];
         tick();
      end
      ld_data = words[10];
      #1;
      chk("ml_we_before", mem_we, 1);
      chk("ml_addr_before", mem_addr, 10);
      rst = 1'b1;
      #1;
      chk("ml_we_async", mem_we, 0);
      chk("ml_ld_ready", ld_ready, 0);
      chk("ml_cpu_hold", cpu_hold, 1);
      chk("ml_word_count", word_count, 0);
      ld_valid = 1'b0;
      tick();
      rst = 1'b0;
      tick();

      // start in RUN with a fetch in the same cycle
      words[0] = 16'hC0DE;
      run_load(1, 1'b1, 1'b0, acc);
      chk("rs_word_count", word_count, 1);
      fetch_req = 1'b1; fetch_addr = 8'd0; start = 1'b1;
      tick();
      start = 1'b0;
      chk("rs_fetch_valid", fetch_valid, 1);
      chk("rs_fetch_data", fetch_data, 16'hC0DE);
      chk("rs_cpu_hold", cpu_hold, 1);
      chk("rs_done", done, 0);
      chk("rs_clear_we", mem_we, 1);
      tick();
      chk("rs_fetch_ignored", fetch_valid, 0);
      fetch_req = 1'b0;
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
